aftab_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single AFTAB memory port between the instruction-fetch unit (I) and the load/store unit (D). It sequences one memory transaction at a time, drives the select of an internal aftab_mux2to1 that steers the address onto the memory bus, and returns per-requester acknowledges. Ties are broken round-robin. A bounded wait counter aborts transactions the memory never completes.

---
 rtl/aftab_mem_arbiter_pkg.sv | 26 ++
 rtl/aftab_mem_arbiter_mux2to1.sv | 13 +
 rtl/aftab_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_aftab_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aftab_mem_arbiter_pkg.sv
// Shared encodings for the AFTAB memory arbiter and the pipeline control unit.
// Also holds the tie-break helper the arbiter uses.
package aftab_mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // prio names the requester that wins the next tie.
    function automatic logic pick_grant(input logic req_i, input logic req_d, input logic prio);
        logic winner;
        if (req_i && req_d) begin
            winner = prio;
        end else if (req_d) begin
            winner = GRANT_D;
        end else begin
            winner = GRANT_I;
        end
        return winner;
    endfunction

endpackage

// File: rtl/aftab_mem_arbiter_mux2to1.sv
// Two-input multiplexer that steers the granted address onto the memory bus.
module aftab_mux2to1 #(
    parameter int size = 32
) (
    input  logic [size-1:0] i0,
    input  logic [size-1:0] i1,
    input  logic            sel,
    output logic [size-1:0] result
);

    assign result = sel ? i1 : i0;

endmodule

// File: rtl/aftab_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and load/store (D),
// with a bounded wait that aborts transactions the memory never completes.
module aftab_mem_arbiter
    import aftab_mem_arbiter_pkg::*;
#(
    parameter int addrWidth     = 32,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reqI,
    input  logic [addrWidth-1:0] addrI,
    input  logic                 reqD,
    input  logic                 writeD,
    input  logic [addrWidth-1:0] addrD,
    input  logic                 memReady,
    output logic [addrWidth-1:0] memAddr,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 grantSel,
    output logic                 ackI,
    output logic                 ackD,
    output logic                 timeoutErr,
    output logic                 busy
);

    localparam int CNT_W = $clog2(timeoutCycles);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(timeoutCycles - 1);

    arb_state_e       state_q, state_d;
    logic             grant_sel_q, grant_sel_d;
    logic             prio_q, prio_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             winner_s;

    // State, grant, tie priority, strobes and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_sel_q   <= GRANT_I;
            prio_q        <= GRANT_D;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_sel_q   <= grant_sel_d;
            prio_q        <= prio_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    // Arbitration in IDLE; completion, counting and abort in BUSY.
    always_comb begin
        state_d       = state_q;
        grant_sel_d   = grant_sel_q;
        prio_d        = prio_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        winner_s      = pick_grant(reqI, reqD, prio_q);
        case (state_q)
            IDLE: begin
                if (reqI || reqD) begin
                    state_d     = BUSY;
                    grant_sel_d = winner_s;
                    prio_d      = ~winner_s;
                    mem_write_d = (winner_s == GRANT_D) && writeD;
                    mem_read_d  = !((winner_s == GRANT_D) && writeD);
                    cnt_d       = '0;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            BUSY: begin
                if (memReady) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d       = IDLE;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    aftab_mux2to1 #(.size(addrWidth)) u_addr_mux (
        .i0     (addrI),
        .i1     (addrD),
        .sel    (grant_sel_q),
        .result (memAddr)
    );

    assign busy       = (state_q == BUSY);
    assign ackI       = busy && memReady && (grant_sel_q == GRANT_I);
    assign ackD       = busy && memReady && (grant_sel_q == GRANT_D);
    assign memRead    = mem_read_q;
    assign memWrite   = mem_write_q;
    assign grantSel   = grant_sel_q;
    assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_aftab_mem_arbiter.sv
// Self-checking bench for aftab_mem_arbiter: directed vector table plus randomized
// traffic compared against a transaction-level reference model.
module tb_aftab_mem_arbiter;

    localparam int AW = 32;
    localparam int TC = 4;
    localparam logic [31:0] A_I = 32'h0000_0100;
    localparam logic [31:0] A_D = 32'h0000_2000;

    logic          clk = 1'b0;
    logic          rst, reqI, reqD, writeD, memReady;
    logic [AW-1:0] addrI, addrD, memAddr;
    logic          memRead, memWrite, grantSel, ackI, ackD, timeoutErr, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aftab_mem_arbiter #(.addrWidth(AW), .timeoutCycles(TC)) dut (
        .clk(clk), .rst(rst), .reqI(reqI), .addrI(addrI), .reqD(reqD),
        .writeD(writeD), .addrD(addrD), .memReady(memReady), .memAddr(memAddr),
        .memRead(memRead), .memWrite(memWrite), .grantSel(grantSel), .ackI(ackI),
        .ackD(ackD), .timeoutErr(timeoutErr), .busy(busy)
    );

    typedef struct {
        logic        r, qi, qd, wd, rdy;
        logic        e_busy, e_rd, e_wr, e_gs, e_ai, e_ad, e_te;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    // Reference model: who owns the port, what kind of access, how long it has waited.
    bit m_busy, m_owner, m_write, m_gsel, m_terr, m_prio;
    int m_waited;

    function automatic vec_t mk(input logic r, qi, qd, wd, rdy,
                                input logic b, rd, wr, gs, ai, ad, te);
        vec_t v;
        v.r = r; v.qi = qi; v.qd = qd; v.wd = wd; v.rdy = rdy;
        v.e_busy = b; v.e_rd = rd; v.e_wr = wr; v.e_gs = gs;
        v.e_ai = ai; v.e_ad = ad; v.e_te = te;
        v.e_addr = gs ? A_D : A_I;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, qi, qd, wd, rdy, input logic [31:0] ai, ad);
        @(negedge clk);
        rst = r; reqI = qi; reqD = qd; writeD = wd; memReady = rdy;
        addrI = ai; addrD = ad;
        #1;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b0; m_gsel = 1'b0; m_prio = 1'b1; m_terr = 1'b0;
            m_write = 1'b0; m_waited = 0; m_owner = 1'b0;
        end else if (m_busy) begin
            m_terr = 1'b0;
            if (memReady) begin
                m_busy = 1'b0;
            end else begin
                m_waited++;
                if (m_waited >= TC) begin
                    m_busy = 1'b0;
                    m_terr = 1'b1;
                end
            end
        end else begin
            m_terr = 1'b0;
            if (reqI || reqD) begin
                m_owner  = (reqI && reqD) ? m_prio : reqD;
                m_prio   = !m_owner;
                m_gsel   = m_owner;
                m_busy   = 1'b1;
                m_waited = 0;
                m_write  = m_owner && writeD;
            end
        end
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_edge();
    endtask

    task automatic check_model(input int cyc);
        string p;
        p = $sformatf("rnd%0d.", cyc);
        check({p, "busy"},       busy,       m_busy);
        check({p, "memRead"},    memRead,    m_busy && !m_write);
        check({p, "memWrite"},   memWrite,   m_busy && m_write);
        check({p, "grantSel"},   grantSel,   m_gsel);
        check({p, "ackI"},       ackI,       m_busy && memReady && !m_owner);
        check({p, "ackD"},       ackD,       m_busy && memReady && m_owner);
        check({p, "timeoutErr"}, timeoutErr, m_terr);
        check({p, "memAddr"},    memAddr,    m_gsel ? addrD : addrI);
    endtask

    initial begin
        // rst qi qd wd rdy | busy rd wr gs ackI ackD te
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
        // reset, then continuous tie with zero-wait memory: D, I, D
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1,0,1,1,0,1,0));
        tbl.push_back(mk(0,1,1,1,1, 0,0,0,1,0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1,1,0,0,1,0,0));
        tbl.push_back(mk(0,1,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1,0,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0,0));
        // D load, ready arrives in the last allowed busy cycle; req dropped mid-way
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,1,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,1, 1,1,0,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0,0));
        // I fetch that never completes -> abort, then a normal fetch
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
        // I fetch completing exactly at the limit
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 1,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0));
        // reset in the second busy cycle of a D store, then a tie goes to D
        tbl.push_back(mk(0,0,1,1,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 1,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,1,1,0, 1,0,1,1,0,0,0));
        tbl.push_back(mk(0,1,1,1,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1, 1,0,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0,0));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A_I, A_D);
        end_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A_I, A_D);
        end_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            string p;
            p = $sformatf("tbl%0d.", i);
            drive(tbl[i].r, tbl[i].qi, tbl[i].qd, tbl[i].wd, tbl[i].rdy, A_I, A_D);
            check({p, "busy"},       busy,       tbl[i].e_busy);
            check({p, "memRead"},    memRead,    tbl[i].e_rd);
            check({p, "memWrite"},   memWrite,   tbl[i].e_wr);
            check({p, "grantSel"},   grantSel,   tbl[i].e_gs);
            check({p, "ackI"},       ackI,       tbl[i].e_ai);
            check({p, "ackD"},       ackD,       tbl[i].e_ad);
            check({p, "timeoutErr"}, timeoutErr, tbl[i].e_te);
            check({p, "memAddr"},    memAddr,    tbl[i].e_addr);
            end_cycle();
        end

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0),
                  $urandom, $urandom);
            check_model(c);
            end_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
